// File: rtl/muldiv_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers; MTHI/MTLO write ports.
// Latency: start edge = cycle 0, busy cycles 1..WIDTH, done pulse in cycle WIDTH+1, for every op and operand.
// Backpressure: start and MTHI/MTLO are ignored while busy; hazard logic stalls on busy. MULDIV_ABORT_EN adds an abort port.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             neg_q;   // product / quotient negate
  logic             neg_r;   // remainder negate (dividend sign)
  logic             div0;
  logic [WIDTH-1:0] opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;  // partial product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / dividend shifting out, quotient shifting in

  logic             abort_req;
`ifdef MULDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Operand conditioning at launch: magnitudes plus sign flags for signed ops.
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sgn   = ~op[0];
  assign sa    = sgn & srca[WIDTH-1];
  assign sb    = sgn & srcb[WIDTH-1];
  assign mag_a = sa ? -srca : srca;
  assign mag_b = sb ? -srcb : srcb;

  // One iteration of either algorithm, evaluated from the current accumulators.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opb});
  assign div_sub = div_sh[WIDTH-1:0] - opb;  // fits in WIDTH bits whenever div_ge holds

  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  assign last = (cnt == CNTW'(1));
  assign prod = {nxt_hi, nxt_lo};

  // Select the shift-add or restoring-divide step, then apply sign fix-ups for the final result.
  always_comb begin
    nxt_hi = '0;
    nxt_lo = '0;
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      nxt_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
      res_lo = div0  ? '1 : (neg_q ? -nxt_lo : nxt_lo);
      // With a zero divisor the remainder path carries the dividend magnitude, so this restores srca.
      res_hi = neg_r ? -nxt_hi : nxt_hi;
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      {res_hi, res_lo} = neg_q ? -prod : prod;
    end
  end

  // Control FSM and iteration datapath; FIN accepts a new start exactly like IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (abort_req) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - CNTW'(1);
            if (last) state <= S_FIN;
          end
        end
        default: begin
          if (start) begin
            state  <= S_RUN;
            cnt    <= CNTW'(WIDTH);
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= op[1] & sa;
            div0   <= (srcb == '0);
            opb    <= op[1] ? mag_b : mag_a;
            acc_lo <= op[1] ? mag_a : mag_b;
            acc_hi <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Architectural HI/LO: final result on the edge entering FIN, MTHI/MTLO only outside RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_RUN) begin
      if (last && !abort_req) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (hi_we) hi <= wd;
      if (lo_we) lo <= wd;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It consumes the same forwarded source operands.
- Owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. The hazard logic stalls on busy.
- MFHI/MFLO read hi/lo directly. MTHI/MTLO write them through dedicated write enables.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
start  input  1  launch operation; sampled only when not busy.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
srca  input  WIDTH  multiplicand or dividend.
srcb  input  WIDTH  multiplier or divisor.
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wd  input  WIDTH  MTHI/MTLO write data.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when hi/lo update from an operation.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, hi=0, lo=0, counter=0.
- States: IDLE, RUN, FIN.
  - IDLE: start=1 at a rising edge latches op and operands, then goes to RUN.
    - Signed ops latch operand magnitudes plus sign flags: quotient/product negate = sa^sb; remainder negate = sa.
    - Counter loads WIDTH.
  - RUN: busy=1. One iteration per cycle; counter decrements. Goes to FIN on the edge where the counter reaches 0.
  - FIN: busy=0, done=1 for exactly one cycle. hi/lo take the final result on the edge entering FIN, so values are visible while done=1.
    - start=1 in FIN is accepted exactly as in IDLE; the next state is RUN.
    - Otherwise the next state is IDLE.
- Latency: start edge at cycle 0; busy high during cycles 1..WIDTH; done high during cycle WIDTH+1. Fixed for all ops and operands.
- Multiply:
  - Shift-add over unsigned magnitudes into a 2*WIDTH-bit product.
  - Two's-complement negated at the end if required.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - Restoring, one quotient bit per cycle. lo = quotient, hi = remainder, signs fixed at the end.
  - Divisor zero: lo = all ones and hi = srca as latched (original signed value), for both DIV and DIVU. Latency is unchanged.
  - DIV of the most negative value by -1: lo = most negative value (wraps), hi = 0.
- start while busy=1: ignored, with no effect on the running operation.
- MTHI/MTLO:
  - hi_we/lo_we update hi/lo from wd at the rising edge, only when busy=0 and the unit is not entering FIN.
  - Ignored while busy=1, so the pipeline must stall.
  - If hi_we and start occur in the same IDLE cycle, the write takes effect and the operation later overwrites it.
- hi_we and lo_we together: both registers take wd.
- hi/lo are never modified during RUN. Intermediate results live in internal registers.

Optional Feature:
Macro: MULDIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at a rising edge while in RUN returns to IDLE. busy falls next cycle; no done pulse; hi/lo unchanged.
  - abort in IDLE/FIN has no effect. abort has priority over completion on the final RUN edge.
  - Used for exception/branch flush.
- Not defined: port absent; every accepted operation runs to completion.

Test Plan:
- Reset: reset=0 mid-RUN of MULTU 7*9 -> immediately busy=0, done=0, hi=0, lo=0. After release, a new op completes normally.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done in cycle 33: hi=0xFFFFFFFE, lo=0x00000001. busy high exactly cycles 1..32.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Back-to-back and hazards:
  - Case A: start asserted during FIN with MULTU 2*3 -> second op accepted; lo=6 at its done.
  - Case B: start pulses and lo_we=1 (wd=0x55) during RUN -> all ignored; lo is the first op's result only.
- MTHI wd=0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged, done stays 0. With MULDIV_ABORT_EN: abort at cycle 10 of DIVU -> busy=0 at cycle 11, no done, hi=0x1234 retained.
